seg_instruction_decode: RTL
===========================

SEG_INSTRUCTION_DECODE -- requirements
Module: seg_instruction_decode

Interface
REQ-001 Parameter LEN, default 32, datapath/instruction/PC width.
REQ-002 Parameter NB_ADDR, default 5, register-file address width (2**NB_ADDR registers).
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_instruction  in  LEN  instruction from fetch stage.
REQ-006 i_PC  in  LEN  already-incremented PC (PC+1, word-addressed) from fetch stage.
REQ-007 i_reg_write / i_write_reg / i_write_data  in  1/NB_ADDR/LEN  write-back port.
REQ-008 i_ID_EX_mem_read / i_ID_EX_rt  in  1/NB_ADDR  load-in-EX hazard inputs.
REQ-009 o_stall_flag  out  1  combinational load-use stall request to fetch.
REQ-010 o_PCSrc / o_PC_branch  out  1/LEN  combinational taken-branch flag and target to fetch.
REQ-011 o_jump / o_PC_dir_jump  out  1/LEN  combinational jump flag and target to fetch.
REQ-012 o_valid, o_PC, o_read_data_1, o_read_data_2, o_sign_extend, o_rs, o_rt, o_rd, o_opcode, o_funct, o_mem_read  out  1/LEN/LEN/LEN/LEN/5/5/5/6/6/1  registered ID/EX fields.

Function
REQ-013 Fields: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0].
REQ-014 Register file: 2**NB_ADDR x LEN; written on rising edge when i_reg_write=1 and i_write_reg!=0; register 0 always reads 0.
REQ-015 Read ports combinational, write-through: read address == i_write_reg (nonzero) with i_reg_write=1 returns i_write_data same cycle.
REQ-016 sign_extend = imm[15] replicated to LEN bits.
REQ-017 Branch (opcode 6'h04 beq, 6'h05 bne): compare read data 1/2 in ID; o_PCSrc=1 when beq equal or bne unequal; o_PC_branch = i_PC + sign_extend, modulo 2**LEN.
REQ-018 Jump (opcode 6'h02 j, 6'h03 jal): o_jump=1, o_PC_dir_jump = {i_PC[LEN-1:26], i_instruction[25:0]}.
REQ-019 Load detect: o_mem_read source = opcode in 6'h20..6'h25.
REQ-020 Hazard: o_stall_flag=1 iff i_ID_EX_mem_read=1 and i_ID_EX_rt!=0 and i_ID_EX_rt equals rs or rt.
REQ-021 While o_stall_flag=1: o_PCSrc=0, o_jump=0 (branch/jump resolves next cycle on correct data).
REQ-022 ID/EX register latency 1 cycle: on each rising edge without stall, all o_* registered fields load decoded values and o_valid<=1.
REQ-023 On a rising edge with stall, a bubble loads: o_valid=0, o_mem_read=0, o_rs/o_rt/o_rd=0, other fields 0.
REQ-024 Branch compare uses no EX/MEM forwarding; only write-through of REQ-015.
REQ-025 Simultaneous stall and write-back: register-file write still occurs.

Reset
REQ-026 Asserting i_rst asynchronously clears all register-file entries and all registered outputs to 0 (o_valid=0).
REQ-027 During reset, writes are ignored; combinational outputs follow decode of current inputs over cleared registers.
REQ-028 First rising edge after deassertion behaves as REQ-022/REQ-023.

Structure
REQ-029 Opcode constants (beq, bne, j, jal, load range) and field-position constants belong in shared package mips_pkg.
REQ-030 Register file is one sub-module, reg_file, holding REQ-014/015/026 behaviour.

Verification
REQ-031 Write r5=32'h0000_00AA, decode add rs=5 rt=0 -> next cycle o_read_data_1=32'hAA, o_read_data_2=0, o_valid=1.
REQ-032 Write r0=32'hFFFF_FFFF then read rs=0 -> o_read_data_1=0; same-cycle write r3=7 with rs=3 -> read 7.
REQ-033 i_PC=10, beq r1=r2=4, imm=16'hFFFE -> o_PCSrc=1, o_PC_branch=8; bne same operands -> o_PCSrc=0.
REQ-034 i_ID_EX_mem_read=1, i_ID_EX_rt=4, instruction rs=4 -> o_stall_flag=1, next edge o_valid=0, o_mem_read=0; i_ID_EX_rt=0 -> no stall.
REQ-035 i_PC=32'h4000_0010, j with target 26'h000_0100 -> o_jump=1, o_PC_dir_jump=32'h4000_0100.
REQ-036 Assert i_rst mid-stream between edges -> outputs and r1..r31 read 0 immediately; pipeline resumes after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and instruction field helpers.
package mips_pkg;

   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned IMM_W    = 16;
   localparam int unsigned TARGET_W = 26;

   // Field positions inside a 32-bit instruction word.
   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned RS_MSB     = 25;
   localparam int unsigned RS_LSB     = 21;
   localparam int unsigned RT_MSB     = 20;
   localparam int unsigned RT_LSB     = 16;
   localparam int unsigned RD_MSB     = 15;
   localparam int unsigned RD_LSB     = 11;
   localparam int unsigned FUNCT_MSB  = 5;
   localparam int unsigned IMM_MSB    = 15;

   // Opcodes this stage acts on.
   localparam logic [OPCODE_W-1:0] OP_J          = 6'h02;
   localparam logic [OPCODE_W-1:0] OP_JAL        = 6'h03;
   localparam logic [OPCODE_W-1:0] OP_BEQ        = 6'h04;
   localparam logic [OPCODE_W-1:0] OP_BNE        = 6'h05;
   localparam logic [OPCODE_W-1:0] OP_LOAD_FIRST = 6'h20;
   localparam logic [OPCODE_W-1:0] OP_LOAD_LAST  = 6'h25;

   // Raw instruction fields.
   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [REG_W-1:0]    rs;
      logic [REG_W-1:0]    rt;
      logic [REG_W-1:0]    rd;
      logic [FUNCT_W-1:0]  funct;
      logic [IMM_W-1:0]    imm;
   } instr_fields_t;

   function automatic instr_fields_t decode_fields(input logic [31:0] instr);
      instr_fields_t f;
      f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
      f.rs     = instr[RS_MSB:RS_LSB];
      f.rt     = instr[RT_MSB:RT_LSB];
      f.rd     = instr[RD_MSB:RD_LSB];
      f.funct  = instr[FUNCT_MSB:0];
      f.imm    = instr[IMM_MSB:0];
      return f;
   endfunction

   function automatic logic is_load(input logic [OPCODE_W-1:0] op);
      return (op >= OP_LOAD_FIRST) && (op <= OP_LOAD_LAST);
   endfunction

   function automatic logic is_jump(input logic [OPCODE_W-1:0] op);
      return (op == OP_J) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: async-cleared storage, r0 hardwired to zero, write-through reads.
module reg_file
   import mips_pkg::*;
#(
   parameter int unsigned LEN     = 32,
   parameter int unsigned NB_ADDR = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_we,
   input  logic [NB_ADDR-1:0] i_waddr,
   input  logic [LEN-1:0]     i_wdata,
   input  logic [NB_ADDR-1:0] i_raddr_1,
   input  logic [NB_ADDR-1:0] i_raddr_2,
   output logic [LEN-1:0]     o_rdata_1,
   output logic [LEN-1:0]     o_rdata_2
);

   localparam int unsigned DEPTH = 2 ** NB_ADDR;

   logic [LEN-1:0] mem_q [DEPTH];
   logic [LEN-1:0] mem_d [DEPTH];
   logic           wr_en;

   // r0 is never written; writes during reset are dropped.
   assign wr_en = i_we && (i_waddr != '0) && !i_rst;

   // Next-state of storage: apply the single write port.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[i_waddr] = i_wdata;
      end
   end

   // Storage update with asynchronous clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read port 1 with same-cycle write bypass.
   always_comb begin
      o_rdata_1 = '0;
      if (i_raddr_1 == '0) begin
         o_rdata_1 = '0;
      end else if (wr_en && (i_raddr_1 == i_waddr)) begin
         o_rdata_1 = i_wdata;
      end else begin
         o_rdata_1 = mem_q[i_raddr_1];
      end
   end

   // Read port 2 with same-cycle write bypass.
   always_comb begin
      o_rdata_2 = '0;
      if (i_raddr_2 == '0) begin
         o_rdata_2 = '0;
      end else if (wr_en && (i_raddr_2 == i_waddr)) begin
         o_rdata_2 = i_wdata;
      end else begin
         o_rdata_2 = mem_q[i_raddr_2];
      end
   end

endmodule

// File: rtl/seg_instruction_decode.sv
// ID stage: decode, register read, early branch/jump resolution, load-use stall, ID/EX register.
module seg_instruction_decode
   import mips_pkg::*;
#(
   parameter int unsigned LEN     = 32,
   parameter int unsigned NB_ADDR = 5
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [LEN-1:0]      i_instruction,
   input  logic [LEN-1:0]      i_PC,
   input  logic                i_reg_write,
   input  logic [NB_ADDR-1:0]  i_write_reg,
   input  logic [LEN-1:0]      i_write_data,
   input  logic                i_ID_EX_mem_read,
   input  logic [NB_ADDR-1:0]  i_ID_EX_rt,
   output logic                o_stall_flag,
   output logic                o_PCSrc,
   output logic [LEN-1:0]      o_PC_branch,
   output logic                o_jump,
   output logic [LEN-1:0]      o_PC_dir_jump,
   output logic                o_valid,
   output logic [LEN-1:0]      o_PC,
   output logic [LEN-1:0]      o_read_data_1,
   output logic [LEN-1:0]      o_read_data_2,
   output logic [LEN-1:0]      o_sign_extend,
   output logic [REG_W-1:0]    o_rs,
   output logic [REG_W-1:0]    o_rt,
   output logic [REG_W-1:0]    o_rd,
   output logic [OPCODE_W-1:0] o_opcode,
   output logic [FUNCT_W-1:0]  o_funct,
   output logic                o_mem_read
);

   instr_fields_t      fld;
   logic [NB_ADDR-1:0] rs_addr;
   logic [NB_ADDR-1:0] rt_addr;
   logic [LEN-1:0]     rdata_1;
   logic [LEN-1:0]     rdata_2;
   logic [LEN-1:0]     sext;
   logic               stall;
   logic               br_taken;

   // ID/EX pipeline register state.
   logic                valid_q,    valid_d;
   logic [LEN-1:0]      pc_q,       pc_d;
   logic [LEN-1:0]      rd1_q,      rd1_d;
   logic [LEN-1:0]      rd2_q,      rd2_d;
   logic [LEN-1:0]      sext_q,     sext_d;
   logic [REG_W-1:0]    rs_q,       rs_d;
   logic [REG_W-1:0]    rt_q,       rt_d;
   logic [REG_W-1:0]    rd_q,       rd_d;
   logic [OPCODE_W-1:0] opcode_q,   opcode_d;
   logic [FUNCT_W-1:0]  funct_q,    funct_d;
   logic                mem_read_q, mem_read_d;

   // Field split of the incoming instruction.
   assign fld     = decode_fields(i_instruction[31:0]);
   assign rs_addr = NB_ADDR'(fld.rs);
   assign rt_addr = NB_ADDR'(fld.rt);
   assign sext    = {{(LEN-IMM_W){fld.imm[IMM_MSB]}}, fld.imm};

   reg_file #(
      .LEN     (LEN),
      .NB_ADDR (NB_ADDR)
   ) u_reg_file (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_we      (i_reg_write),
      .i_waddr   (i_write_reg),
      .i_wdata   (i_write_data),
      .i_raddr_1 (rs_addr),
      .i_raddr_2 (rt_addr),
      .o_rdata_1 (rdata_1),
      .o_rdata_2 (rdata_2)
   );

   // Load-use hazard and early control-flow resolution.
   always_comb begin
      stall    = i_ID_EX_mem_read && (i_ID_EX_rt != '0) &&
                 ((i_ID_EX_rt == rs_addr) || (i_ID_EX_rt == rt_addr));
      br_taken = ((fld.opcode == OP_BEQ) && (rdata_1 == rdata_2)) ||
                 ((fld.opcode == OP_BNE) && (rdata_1 != rdata_2));
   end

   assign o_stall_flag  = stall;
   assign o_PCSrc       = br_taken && !stall;
   assign o_PC_branch   = i_PC + sext;
   assign o_jump        = is_jump(fld.opcode) && !stall;
   assign o_PC_dir_jump = {i_PC[LEN-1:TARGET_W], i_instruction[TARGET_W-1:0]};

   // ID/EX next state: bubble on stall, decoded values otherwise.
   always_comb begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rd1_d      = '0;
      rd2_d      = '0;
      sext_d     = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      opcode_d   = '0;
      funct_d    = '0;
      mem_read_d = 1'b0;
      if (!stall) begin
         valid_d    = 1'b1;
         pc_d       = i_PC;
         rd1_d      = rdata_1;
         rd2_d      = rdata_2;
         sext_d     = sext;
         rs_d       = fld.rs;
         rt_d       = fld.rt;
         rd_d       = fld.rd;
         opcode_d   = fld.opcode;
         funct_d    = fld.funct;
         mem_read_d = is_load(fld.opcode);
      end
   end

   // ID/EX register with asynchronous clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         sext_q     <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         opcode_q   <= '0;
         funct_q    <= '0;
         mem_read_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
         sext_q     <= sext_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         opcode_q   <= opcode_d;
         funct_q    <= funct_d;
         mem_read_q <= mem_read_d;
      end
   end

   assign o_valid       = valid_q;
   assign o_PC          = pc_q;
   assign o_read_data_1 = rd1_q;
   assign o_read_data_2 = rd2_q;
   assign o_sign_extend = sext_q;
   assign o_rs          = rs_q;
   assign o_rt          = rt_q;
   assign o_rd          = rd_q;
   assign o_opcode      = opcode_q;
   assign o_funct       = funct_q;
   assign o_mem_read    = mem_read_q;

endmodule
